// File: rtl/music_seq_reader.sv
// rtl/music_seq_reader.sv - walks song memory from address 0, playing each {period, dur} entry as a timed square wave
// Optional feature macro: MUSIC_SEQ_LOOP_EN (restart from address 0 instead of finishing the song)
module music_seq_reader #(
  parameter int ADDR_W   = 5,
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      tick,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [PERIOD_W+DUR_W-1:0] mem_data,
  output logic                      audio_out,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                audio_q, audio_d;

  logic [PERIOD_W-1:0] entry_period;
  logic [DUR_W-1:0]    entry_dur;
  logic                note_end;
  logic                song_wrap;
  logic                marker_wrap;

  assign entry_period = mem_data[PERIOD_W+DUR_W-1:DUR_W];
  assign entry_dur    = mem_data[DUR_W-1:0];
  // The final duration tick ends the note even if a half-period toggle is due the same cycle
  assign note_end     = tick && (dur_q == DUR_W'(1));

`ifdef MUSIC_SEQ_LOOP_EN
  // An end marker at address 0 means an empty song; finishing there keeps the loop from spinning
  assign song_wrap   = 1'b1;
  assign marker_wrap = (addr_q != '0);
`else
  assign song_wrap   = 1'b0;
  assign marker_wrap = 1'b0;
`endif

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      period_q <= '0;
      half_q   <= '0;
      dur_q    <= '0;
      audio_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      period_q <= period_d;
      half_q   <= half_d;
      dur_q    <= dur_d;
      audio_q  <= audio_d;
    end
  end

  // Next-state selection; stop always returns to IDLE from the busy states
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!stop && start) state_d = S_FETCH;
      S_FETCH: state_d = stop ? S_IDLE : S_LOAD;
      S_LOAD: begin
        if (stop)                 state_d = S_IDLE;
        else if (entry_dur == '0) state_d = marker_wrap ? S_FETCH : S_DONE;
        else                      state_d = S_PLAY;
      end
      S_PLAY: begin
        if (stop)          state_d = S_IDLE;
        else if (note_end) state_d = (addr_q != LAST_ADDR || song_wrap) ? S_FETCH : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address, tone and duration counters; audio is forced low outside an ongoing note
  always_comb begin
    addr_d   = addr_q;
    period_d = period_q;
    half_d   = half_q;
    dur_d    = dur_q;
    audio_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!stop && start) addr_d = '0;
      end
      S_LOAD: begin
        if (!stop) begin
          if (entry_dur == '0) begin
            if (marker_wrap) addr_d = '0;
          end else begin
            period_d = entry_period;
            half_d   = '0;
            dur_d    = entry_dur;
          end
        end
      end
      S_PLAY: begin
        if (!stop) begin
          if (note_end) begin
            dur_d  = '0;
            half_d = '0;
            if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
            else if (song_wrap)      addr_d = '0;
          end else begin
            audio_d = audio_q;
            if (tick) dur_d = dur_q - DUR_W'(1);
            if (period_q != '0) begin
              if (half_q == period_q - PERIOD_W'(1)) begin
                half_d  = '0;
                audio_d = ~audio_q;
              end else begin
                half_d = half_q + PERIOD_W'(1);
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the current state and registers
  always_comb begin
    mem_addr  = addr_q;
    audio_out = audio_q;
    busy      = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);
    done      = (state_q == S_DONE);
  end

endmodule
